// File: rtl/exibe_sequencia.sv
// exibe_sequencia: presenter side of the mindfocus game.
// Plays ROM entries 0..limite on the LEDs with fixed on/off timing, then pulses fim.
// Optional build macro: CHECA_ONEHOT_EN (rejects ROM words that are not exactly one-hot).
//
// Handshake: iniciar is a start request honoured only while ocupado=0 (state INICIAL);
// limite is captured on that same edge. ocupado stays high from LE through FIM, and fim
// is a single-cycle pulse marking the end (or abort) of the run. There is no back-pressure.
module exibe_sequencia #(
  parameter int ADDR_W = 4,
  parameter int T_ON   = 25_000_000,
  parameter int T_OFF  = 12_500_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [3:0]        dado,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              ocupado,
  output logic              fim,
  output logic              erro,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    LE      = 4'd1,
    ESPERA  = 4'd2,
    ACENDE  = 4'd3,
    APAGA   = 4'd4,
    FIM     = 4'd5
  } estado_t;

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = $clog2(T_MAX) + 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);
  localparam logic [TW-1:0] TMR_SAT  = '1;

  estado_t           r_estado, w_estado_nx;
  logic [TW-1:0]     r_timer,  w_timer_nx;
  logic [ADDR_W-1:0] r_end,    w_end_nx;
  logic [ADDR_W-1:0] r_lim,    w_lim_nx;
  logic [3:0]        r_word,   w_word_nx;
  logic [TW-1:0]     w_timer_inc;

  // Saturating increment: the timer never wraps even if held past its terminal count.
  assign w_timer_inc = (r_timer == TMR_SAT) ? r_timer : r_timer + TW'(1);

`ifdef CHECA_ONEHOT_EN
  logic r_erro, w_erro_nx;
  logic w_onehot;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign w_onehot = (dado != 4'd0) && ((dado & (dado - 4'd1)) == 4'd0);
`endif

  // Next-state and datapath update logic; every target defaults to holding its value.
  always_comb begin
    w_estado_nx = r_estado;
    w_timer_nx  = r_timer;
    w_end_nx    = r_end;
    w_lim_nx    = r_lim;
    w_word_nx   = r_word;
`ifdef CHECA_ONEHOT_EN
    w_erro_nx   = r_erro;
`endif
    case (r_estado)
      INICIAL: begin
        if (iniciar) begin
          w_lim_nx    = limite;
          w_end_nx    = '0;
`ifdef CHECA_ONEHOT_EN
          w_erro_nx   = 1'b0;
`endif
          w_estado_nx = LE;
        end
      end
      // Address is stable here; the synchronous ROM registers it on this edge.
      LE: w_estado_nx = ESPERA;
      ESPERA: begin
        w_timer_nx  = '0;
`ifdef CHECA_ONEHOT_EN
        if (!w_onehot) begin
          w_erro_nx   = 1'b1;
          w_word_nx   = 4'd0;
          w_estado_nx = FIM;
        end else begin
          w_word_nx   = dado;
          w_estado_nx = ACENDE;
        end
`else
        w_word_nx   = dado;
        w_estado_nx = ACENDE;
`endif
      end
      ACENDE: begin
        if (r_timer == ON_LAST) begin
          w_timer_nx  = '0;
          w_estado_nx = APAGA;
        end else begin
          w_timer_nx  = w_timer_inc;
        end
      end
      APAGA: begin
        if (r_timer == OFF_LAST) begin
          w_timer_nx = '0;
          // Leave before incrementing so the last address never wraps to 0.
          if (r_end == r_lim) begin
            w_estado_nx = FIM;
          end else begin
            w_end_nx    = r_end + ADDR_W'(1);
            w_estado_nx = LE;
          end
        end else begin
          w_timer_nx = w_timer_inc;
        end
      end
      FIM:     w_estado_nx = INICIAL;
      default: w_estado_nx = INICIAL;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
      r_timer  <= '0;
      r_end    <= '0;
      r_lim    <= '0;
      r_word   <= 4'd0;
`ifdef CHECA_ONEHOT_EN
      r_erro   <= 1'b0;
`endif
    end else begin
      r_estado <= w_estado_nx;
      r_timer  <= w_timer_nx;
      r_end    <= w_end_nx;
      r_lim    <= w_lim_nx;
      r_word   <= w_word_nx;
`ifdef CHECA_ONEHOT_EN
      r_erro   <= w_erro_nx;
`endif
    end
  end

  // Outputs decoded from registered state only, so the LED drive cannot glitch.
  assign endereco  = r_end;
  assign leds      = (r_estado == ACENDE) ? r_word : 4'd0;
  assign ocupado   = (r_estado != INICIAL);
  assign fim       = (r_estado == FIM);
  assign db_estado = 4'(r_estado);
`ifdef CHECA_ONEHOT_EN
  assign erro      = r_erro;
`else
  assign erro      = 1'b0;
`endif

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia: sync ROM model, expected per-cycle trace built from the
// game rules (entry = address, fetch, T_ON lit, T_OFF dark; then one fim cycle).
module tb_exibe_sequencia;
  localparam int ADDR_W = 4;
  localparam int T_ON   = 4;
  localparam int T_OFF  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar;
  logic [ADDR_W-1:0] limite;
  logic [3:0]        dado;
  logic [ADDR_W-1:0] endereco;
  logic [3:0]        leds;
  logic              ocupado, fim, erro;
  logic [3:0]        db_estado;

  logic [3:0] rom [0:15];

  typedef struct packed {
    logic [3:0]        st;
    logic [3:0]        led;
    logic [ADDR_W-1:0] addr;
    logic              fim;
    logic              erro;
  } exp_t;

  exp_t exp_q[$];
  logic exp_erro_end;
  int   checks = 0;
  int   errors = 0;

  exibe_sequencia #(.ADDR_W(ADDR_W), .T_ON(T_ON), .T_OFF(T_OFF)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite), .dado(dado),
    .endereco(endereco), .leds(leds), .ocupado(ocupado), .fim(fim), .erro(erro),
    .db_estado(db_estado)
  );

  // Clock
  always #5 clock = ~clock;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clock) dado <= rom[endereco];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input logic e_erro);
    chk("idle_estado", 32'(db_estado), 32'd0);
    chk("idle_leds", 32'(leds), 32'd0);
    chk("idle_fim", 32'(fim), 32'd0);
    chk("idle_ocupado", 32'(ocupado), 32'd0);
    chk("idle_erro", 32'(erro), 32'(e_erro));
  endtask

  task automatic add(input int st, input logic [3:0] led, input int addr, input logic f,
                     input logic e);
    exp_t x;
    x.st = 4'(st); x.led = led; x.addr = ADDR_W'(addr); x.fim = f; x.erro = e;
    exp_q.push_back(x);
  endtask

  // Reference trace for one run of entries 0..lim from the current ROM contents.
  task automatic build(input int lim);
    logic [3:0] w;
    logic err_now;
    err_now = 1'b0;
    exp_q.delete();
    for (int i = 0; i <= lim; i++) begin
      w = rom[i];
      add(1, 4'd0, i, 1'b0, err_now);
      add(2, 4'd0, i, 1'b0, err_now);
`ifdef CHECA_ONEHOT_EN
      if ($countones(w) != 1) begin
        add(5, 4'd0, i, 1'b1, 1'b1);
        exp_erro_end = 1'b1;
        return;
      end
`endif
      repeat (T_ON)  add(3, w, i, 1'b0, err_now);
      repeat (T_OFF) add(4, 4'd0, i, 1'b0, err_now);
    end
    add(5, 4'd0, lim, 1'b1, err_now);
    exp_erro_end = err_now;
  endtask

  // poke_kind: 0 none, 1 iniciar+limite=0 while busy, 2 reset asserted at poke_idx.
  task automatic run(input int lim, input int poke_idx, input int poke_kind);
    exp_t e;
    int   idx;
    build(lim);
    @(negedge clock);
    iniciar = 1'b1; limite = ADDR_W'(lim);
    @(negedge clock);
    iniciar = 1'b0; limite = ADDR_W'($urandom_range(0, 15));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("estado[%0d]", idx), 32'(db_estado), 32'(e.st));
      chk($sformatf("leds[%0d]", idx), 32'(leds), 32'(e.led));
      chk($sformatf("endereco[%0d]", idx), 32'(endereco), 32'(e.addr));
      chk($sformatf("fim[%0d]", idx), 32'(fim), 32'(e.fim));
      chk($sformatf("erro[%0d]", idx), 32'(erro), 32'(e.erro));
      chk($sformatf("ocupado[%0d]", idx), 32'(ocupado), 32'd1);
      if (idx == poke_idx && poke_kind == 2) begin
        reset = 1'b0;
        #1;
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_estado", 32'(db_estado), 32'd0);
        chk("rst_endereco", 32'(endereco), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        exp_erro_end = 1'b0;
        exp_q.delete();
        break;
      end
      if (idx == poke_idx && poke_kind == 1) begin
        iniciar = 1'b1; limite = '0;
      end else begin
        iniciar = 1'b0;
      end
      idx++;
      @(negedge clock);
    end
    iniciar = 1'b0;
    repeat (3) begin
      chk_idle(exp_erro_end);
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; limite = '0;
    for (int i = 0; i < 16; i++) rom[i] = 4'd1 << $urandom_range(0, 3);

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_endereco", 32'(endereco), 32'd0);
    chk_idle(1'b0);
    reset = 1'b1;
    @(negedge clock);

    // Single entry
    rom[0] = 4'b0100;
    run(0, -1, 0);

    // Full run with a start request and limite change injected during ACENDE of entry 1
    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
    run(3, 11, 1);

    // Maximum length: all 16 entries, no wrap
    for (int i = 0; i < 16; i++) rom[i] = 4'd1 << $urandom_range(0, 3);
    run(15, -1, 0);

    // Randomized runs with arbitrary ROM words
    repeat (3) begin
      for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
      run($urandom_range(0, 15), -1, 0);
    end

    // Non-one-hot word at entry 1
    rom[0] = 4'b1000; rom[1] = 4'b0011; rom[2] = 4'b0001; rom[3] = 4'b0010;
    run(3, -1, 0);

    // Reset in the middle of ACENDE of entry 0
    rom[0] = 4'b0010;
    run(3, 3, 2);
    run(0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
